// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces one raw push-button pin.
// Output: a clean pressed level (key_value) plus a one-cycle change strobe (key_valid).
// Optional feature macro: KEY_LONG_PRESS_EN adds a one-cycle long_press strobe.
// The strobe fires once the key has been held for LONG_PRESS_MS.
module key_debounce #(
    parameter int unsigned CLK_FREQ       = 125_000_000,
    parameter int unsigned DEBOUNCE_MS    = 20,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_PRESS_MS  = 1000
) (
    input  logic clk_125M,
    input  logic rst,
    input  logic key_in,
    output logic key_value,
    output logic key_valid
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int unsigned DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Pin level while the button is released.
    localparam logic PIN_IDLE = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StPressed,
        StReleaseChk
    } state_e;

    logic            sync1_q, sync2_q;
    logic            n_in;
    state_e          state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_value_q, key_value_d;
    logic            key_valid_q, key_valid_d;

    // Two-flop synchroniser for the asynchronous pin, reset to the idle level.
    always_ff @(posedge clk_125M or posedge rst) begin
        if (rst) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity: 1 means pressed regardless of pin wiring.
    assign n_in = sync2_q ^ KEY_ACTIVE_LOW;

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk_125M or posedge rst) begin
        if (rst) begin
            state_q     <= StReleased;
            db_cnt_q    <= '0;
            key_value_q <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic: a candidate level must persist DB_CYCLES checks to be confirmed.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        key_value_d = key_value_q;
        key_valid_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (n_in) begin
                    state_d  = StPressChk;
                    db_cnt_d = '0;
                end
            end
            StPressChk: begin
                if (!n_in) begin
                    state_d  = StReleased;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = StPressed;
                    db_cnt_d    = '0;
                    key_value_d = 1'b1;
                    key_valid_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!n_in) begin
                    state_d  = StReleaseChk;
                    db_cnt_d = '0;
                end
            end
            StReleaseChk: begin
                if (n_in) begin
                    state_d  = StPressed;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = StReleased;
                    db_cnt_d    = '0;
                    key_value_d = 1'b0;
                    key_valid_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = StReleased;
                db_cnt_d = '0;
            end
        endcase
    end

    assign key_value = key_value_q;
    assign key_valid = key_valid_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LP_CYCLES = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int unsigned LP_W      = (LP_CYCLES > 1) ? $clog2(LP_CYCLES) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);

    logic [LP_W-1:0] long_cnt_q, long_cnt_d;
    logic            long_done_q, long_done_d;
    logic            long_press_q, long_press_d;

    // Hold-time counter registers.
    always_ff @(posedge clk_125M or posedge rst) begin
        if (rst) begin
            long_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_done_q  <= long_done_d;
            long_press_q <= long_press_d;
        end
    end

    // Count only while staying in StPressed; any entry or exit restarts the hold.
    always_comb begin
        long_cnt_d   = '0;
        long_done_d  = 1'b0;
        long_press_d = 1'b0;
        if (state_q == StPressed && state_d == StPressed) begin
            long_done_d = long_done_q;
            if (long_cnt_q != LP_LAST) begin
                long_cnt_d = long_cnt_q + 1'b1;
            end else begin
                // Counter holds; the done flag limits the strobe to one per hold.
                long_cnt_d = long_cnt_q;
                if (!long_done_q) begin
                    long_press_d = 1'b1;
                    long_done_d  = 1'b1;
                end
            end
        end
    end

    assign long_press = long_press_q;
`else
    // Hold time has no effect without the long-press feature; keep it referenced.
    if (LONG_PRESS_MS != 0) begin : g_long_press_unused
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a run-length reference model.
// Define KEY_LONG_PRESS_EN on both files to also check the long_press strobe.
module tb_key_debounce;

    localparam int unsigned DB = 4;   // 1000 Hz * 4 ms
    localparam int unsigned LP = 10;  // 1000 Hz * 10 ms

    logic clk_125M = 1'b0;
    logic rst      = 1'b0;
    logic key_in   = 1'b1;
    logic key_value;
    logic key_valid;
`ifdef KEY_LONG_PRESS_EN
    logic long_press;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model: pin history seen through two sample delays, debounced by run length.
    logic m_pin_q[$];
    logic m_level;
    int   m_run;
    int   m_stay;
    logic m_valid;
    logic m_long;

    // Observation window counters.
    int win_cnt, win_first, win_long_cnt, win_long_first;

    key_debounce #(
        .CLK_FREQ      (1000),
        .DEBOUNCE_MS   (4),
        .KEY_ACTIVE_LOW(1'b1),
        .LONG_PRESS_MS (10)
    ) dut (
        .clk_125M  (clk_125M),
        .rst       (rst),
        .key_in    (key_in),
        .key_value (key_value),
        .key_valid (key_valid)
`ifdef KEY_LONG_PRESS_EN
        ,
        .long_press(long_press)
`endif
    );

    always #5 clk_125M = ~clk_125M;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pin_q = '{1'b1, 1'b1};
        m_level = 1'b0;
        m_run   = 0;
        m_stay  = 0;
        m_valid = 1'b0;
        m_long  = 1'b0;
    endtask

    // One clock edge: the debouncer sees the pin value from two edges ago.
    task automatic model_edge();
        logic seen;
        logic pressed;
        bit   was_pressed;
        seen = m_pin_q.pop_front();
        m_pin_q.push_back(key_in);
        pressed     = ~seen;
        was_pressed = m_level && (m_run == 0);
        m_valid = 1'b0;
        m_long  = 1'b0;
        if (pressed != m_level) begin
            m_run++;
            // One edge to notice the change, then DB edges of agreement.
            if (m_run == DB + 1) begin
                m_level = pressed;
                m_valid = 1'b1;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        if (m_level && m_run == 0) begin
            if (!was_pressed) begin
                m_stay = 0;
            end else begin
                m_stay++;
                if (m_stay == LP) m_long = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_125M);
        if (rst) model_reset();
        else model_edge();
        #1;
        check("key_value", key_value, m_level);
        check("key_valid", key_valid, m_valid);
`ifdef KEY_LONG_PRESS_EN
        check("long_press", long_press, m_long);
`endif
    endtask

    // Run n edges; edge index 0 is the first edge after the call.
    task automatic watch(input int n);
        win_cnt        = 0;
        win_first      = -1;
        win_long_cnt   = 0;
        win_long_first = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (key_valid === 1'b1) begin
                if (win_first < 0) win_first = i;
                win_cnt++;
            end
`ifdef KEY_LONG_PRESS_EN
            if (long_press === 1'b1) begin
                if (win_long_first < 0) win_long_first = i;
                win_long_cnt++;
            end
`endif
        end
    endtask

    initial begin
        int c0, c1;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_key_value", key_value, 1'b0);
        check("rst_key_valid", key_valid, 1'b0);
`ifdef KEY_LONG_PRESS_EN
        check("rst_long_press", long_press, 1'b0);
`endif
        step();
        step();
        rst = 1'b0;
        watch(50);
        check_int("idle_strobes", win_cnt, 0);

        // Clean press and release
        key_in = 1'b0;
        watch(12);
        check_int("press_edge", win_first, 6);
        check_int("press_count", win_cnt, 1);
        check("press_level", key_value, 1'b1);
        key_in = 1'b1;
        watch(12);
        check_int("release_edge", win_first, 6);
        check_int("release_count", win_cnt, 1);
        check("release_level", key_value, 1'b0);

        // Bounce: 3 low, 2 high, then held low
        key_in = 1'b0;
        watch(3);
        c0 = win_cnt;
        key_in = 1'b1;
        watch(2);
        c1 = win_cnt;
        key_in = 1'b0;
        watch(12);
        check_int("bounce_early_strobes", c0 + c1, 0);
        check_int("bounce_edge", win_first, 6);
        check_int("bounce_count", win_cnt, 1);
        key_in = 1'b1;
        watch(12);
        check_int("bounce_release_count", win_cnt, 1);

        // Revert on the final debounce cycle
        key_in = 1'b0;
        watch(4);
        c0 = win_cnt;
        key_in = 1'b1;
        watch(15);
        check_int("revert_strobes", c0 + win_cnt, 0);
        check("revert_level", key_value, 1'b0);

        // Reset while in the press check
        key_in = 1'b0;
        watch(4);
        c0 = win_cnt;
        #2 rst = 1'b1;
        #1;
        check("midrst_key_value", key_value, 1'b0);
        check("midrst_key_valid", key_valid, 1'b0);
        step();
        step();
        rst = 1'b0;
        watch(12);
        check_int("midrst_pre_strobes", c0, 0);
        check_int("midrst_edge", win_first, 6);
        check_int("midrst_count", win_cnt, 1);
        key_in = 1'b1;
        watch(12);
        check_int("midrst_release_count", win_cnt, 1);

`ifdef KEY_LONG_PRESS_EN
        // Long hold: one long_press ten edges after the press strobe
        key_in = 1'b0;
        watch(30);
        check_int("long_press_edge", win_long_first, win_first + 10);
        check_int("long_press_count", win_long_cnt, 1);
        key_in = 1'b1;
        watch(12);
        check_int("long_after_release", win_long_cnt, 0);
        // Short hold: no long_press
        key_in = 1'b0;
        watch(5);
        c0 = win_long_cnt;
        key_in = 1'b1;
        watch(15);
        check_int("short_hold_long", c0 + win_long_cnt, 0);
`endif

        // Random pin activity against the model
        for (int s = 0; s < 250; s++) begin
            int len;
            key_in = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 25) : $urandom_range(1, 7);
            watch(len);
        end
        key_in = 1'b1;
        watch(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
